// File: rtl/imem_resp_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_resp_pkg;

    localparam int INST_W = 16;
    localparam logic [INST_W-1:0] NOP_INST = 16'h0800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, registered read; a same-word write
// and read on one edge returns the old word.
module imem_array
    import imem_resp_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [INST_W-1:0] rd_data
);

    logic [INST_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register is cleared so resp_inst reads 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_resp.sv
// Instruction-memory responder: accepts fetch addresses, returns the addressed
// word after LATENCY cycles, supports backpressure, flush and preload.
module imem_resp
    import imem_resp_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [15:0]       req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_valid,
    output logic [INST_W-1:0] resp_inst,
    output logic [15:0]       resp_addr,
    output logic              resp_err,
    input  logic              resp_ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [INST_W-1:0] ld_data
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q;
    logic        load;
    logic        accept;
    logic        fault;
    logic [INST_W-1:0] rd_data;

    assign accept = req_valid & req_ready;
    assign fault  = addr_q[0] | ((addr_q >> (ADDR_W + 1)) != 16'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !flush;
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = 3'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                req_ready = resp_ready & !flush;
                if (resp_ready) begin
                    if (req_valid) begin
                        state_d = WAIT;
                        cnt_d   = 3'(LATENCY - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Redirect overrides everything, including a pending load.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            resp_valid <= 1'b0;
            resp_addr  <= 16'd0;
            resp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush) begin
                resp_valid <= 1'b0;
            end else if (load) begin
                resp_valid <= 1'b1;
                resp_addr  <= addr_q;
                resp_err   <= fault;
            end else if (state_q == HOLD && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= req_addr;
        end
    end

    imem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (load & !fault),
        .rd_addr (addr_q[ADDR_W:1]),
        .rd_data (rd_data)
    );

    // Faulted fetches never read the array; present the NOP instead.
    assign resp_inst = resp_err ? NOP_INST : rd_data;

endmodule
